fabric_arbiter: RTL and testbench

//  Request side of switch_fabric: produces the grant[] vector that switch_fabric consumes.

---
 rtl/fabric_arbiter.sv | 100 ++++++++++
 tb/tb_fabric_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_arbiter.sv
// Request-side arbiter for switch_fabric: one round-robin arbiter per output port,
// each locking to a single input for a whole packet and gated by out_ready.
module fabric_arbiter #(
   parameter int N_PORTS = 8,
   parameter int ADDR_W  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_PORTS-1:0]          req,
   input  logic [N_PORTS-1:0]          last,
   input  logic [N_PORTS*ADDR_W-1:0]   addr,
   input  logic [N_PORTS-1:0]          out_ready,
   output logic [N_PORTS-1:0]          grant,
   output logic [N_PORTS-1:0]          busy,
   output logic [N_PORTS-1:0]          addr_err
);

   localparam int          IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam logic [31:0] N_PORTS_U = N_PORTS;

   typedef enum logic {S_IDLE, S_LOCKED} out_state_e;

   out_state_e         state_q [N_PORTS];
   out_state_e         state_d [N_PORTS];
   logic [IDX_W-1:0]   owner_q [N_PORTS];
   logic [IDX_W-1:0]   owner_d [N_PORTS];
   logic [IDX_W-1:0]   ptr_q   [N_PORTS];
   logic [IDX_W-1:0]   ptr_d   [N_PORTS];
   logic [N_PORTS-1:0] addr_err_q;
   logic [N_PORTS-1:0] addr_err_d;
   logic [N_PORTS-1:0] owned;

   // Grant depends only on registered lock state and out_ready, never on req/addr.
   always_comb begin
      owned = '0;
      grant = '0;
      busy  = '0;
      for (int unsigned o = 0; o < N_PORTS; o++) begin
         if (state_q[o] == S_LOCKED) begin
            owned[owner_q[o]] = 1'b1;
            busy[o]           = 1'b1;
            if (out_ready[o]) grant[owner_q[o]] = 1'b1;
         end
      end
   end

   always_comb begin
      logic             found;
      logic [IDX_W-1:0] idx;
      found = 1'b0;
      idx   = '0;
      for (int unsigned o = 0; o < N_PORTS; o++) begin
         state_d[o] = state_q[o];
         owner_d[o] = owner_q[o];
         ptr_d[o]   = ptr_q[o];
         if (state_q[o] == S_LOCKED) begin
            if (out_ready[o] && req[owner_q[o]] && last[owner_q[o]]) begin
               state_d[o] = S_IDLE;
               ptr_d[o]   = owner_q[o] + 1'b1;
            end
         end else begin
            found = 1'b0;
            // Inputs already owning an output are skipped so an input never holds two locks.
            for (int unsigned k = 0; k < N_PORTS; k++) begin
               idx = ptr_q[o] + IDX_W'(k);
               if (!found && req[idx] && !owned[idx] &&
                   addr[idx*ADDR_W +: ADDR_W] == ADDR_W'(o)) begin
                  found      = 1'b1;
                  state_d[o] = S_LOCKED;
                  owner_d[o] = idx;
               end
            end
         end
      end
      for (int unsigned i = 0; i < N_PORTS; i++) begin
         addr_err_d[i] = req[i] && (32'(addr[i*ADDR_W +: ADDR_W]) >= N_PORTS_U);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned o = 0; o < N_PORTS; o++) begin
            state_q[o] <= S_IDLE;
            owner_q[o] <= '0;
            ptr_q[o]   <= '0;
         end
         addr_err_q <= '0;
      end else begin
         for (int unsigned o = 0; o < N_PORTS; o++) begin
            state_q[o] <= state_d[o];
            owner_q[o] <= owner_d[o];
            ptr_q[o]   <= ptr_d[o];
         end
         addr_err_q <= addr_err_d;
      end
   end

   assign addr_err = addr_err_q;

endmodule

// File: tb/tb_fabric_arbiter.sv
// Bench for fabric_arbiter: directed scenarios plus randomized traffic, every cycle
// checked against a packet-level reference model of the per-output arbiters.
module tb_fabric_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req, last, out_ready, grant, busy, addr_err;
   logic [31:0] addr;

   fabric_arbiter #(.N_PORTS(8), .ADDR_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last), .addr(addr),
      .out_ready(out_ready), .grant(grant), .busy(busy), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Requester side: remaining beats, destination, and a voluntary pause per input.
   int   plen [8];
   int   dst  [8];
   bit   pause[8];

   // Reference model state.
   bit   m_lock[8];
   int   m_own [8];
   int   m_ptr [8];
   bit [7:0] m_err;

   logic [7:0] g_obs, b_obs, e_obs;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic bit [7:0] exp_grant();
      bit [7:0] g = '0;
      for (int o = 0; o < 8; o++) if (m_lock[o] && out_ready[o]) g[m_own[o]] = 1'b1;
      return g;
   endfunction

   function automatic bit [7:0] exp_busy();
      bit [7:0] b = '0;
      for (int o = 0; o < 8; o++) b[o] = m_lock[o];
      return b;
   endfunction

   task automatic model_reset();
      for (int o = 0; o < 8; o++) begin
         m_lock[o] = 0; m_own[o] = 0; m_ptr[o] = 0;
      end
      m_err = '0;
   endtask

   task automatic model_step();
      bit nl[8]; int nown[8]; int nptr[8];
      bit [7:0] owned = '0;
      for (int o = 0; o < 8; o++) if (m_lock[o]) owned[m_own[o]] = 1'b1;
      for (int o = 0; o < 8; o++) begin
         nl[o] = m_lock[o]; nown[o] = m_own[o]; nptr[o] = m_ptr[o];
         if (m_lock[o]) begin
            if (out_ready[o] && req[m_own[o]] && last[m_own[o]]) begin
               nl[o] = 0; nptr[o] = (m_own[o] + 1) % 8;
            end
         end else begin
            for (int k = 0; k < 8; k++) begin
               int i = (m_ptr[o] + k) % 8;
               if (req[i] && int'(addr[i*4 +: 4]) == o && !owned[i]) begin
                  nl[o] = 1; nown[o] = i;
                  break;
               end
            end
         end
      end
      for (int o = 0; o < 8; o++) begin
         m_lock[o] = nl[o]; m_own[o] = nown[o]; m_ptr[o] = nptr[o];
      end
      for (int i = 0; i < 8; i++) m_err[i] = req[i] && (int'(addr[i*4 +: 4]) >= 8);
   endtask

   task automatic drive();
      for (int i = 0; i < 8; i++) begin
         req[i]          = (plen[i] > 0) && !pause[i];
         last[i]         = (plen[i] == 1);
         addr[i*4 +: 4]  = dst[i][3:0];
      end
   endtask

   task automatic start(input int i, input int d, input int len);
      dst[i] = d; plen[i] = len; pause[i] = 0;
      drive();
   endtask

   // One clock: compare against the model before the edge, then advance model and requesters.
   task automatic tick();
      bit [7:0] eg;
      #2;
      eg = exp_grant();
      g_obs = grant; b_obs = busy; e_obs = addr_err;
      chk("grant", {24'd0, grant}, {24'd0, eg});
      chk("busy", {24'd0, busy}, {24'd0, exp_busy()});
      chk("addr_err", {24'd0, addr_err}, {24'd0, m_err});
      @(posedge clk);
      model_step();
      for (int i = 0; i < 8; i++) if (eg[i] && req[i] && plen[i] > 0) plen[i]--;
      #1;
      drive();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      bit pending = 1;
      while (pending && n < budget) begin
         pending = 0;
         for (int i = 0; i < 8; i++) if (plen[i] > 0) pending = 1;
         for (int o = 0; o < 8; o++) if (m_lock[o]) pending = 1;
         if (pending) begin tick(); n++; end
      end
      chk("drain_timeout", {31'd0, pending}, 32'd0);
   endtask

   initial begin
      bit [7:0] g3, g6;
      rst_n = 1'b0; out_ready = 8'hFF;
      for (int i = 0; i < 8; i++) begin plen[i] = 0; dst[i] = 0; pause[i] = 0; end
      drive();
      model_reset();
      #7;
      chk("rst_grant", {24'd0, grant}, 32'd0);
      chk("rst_busy", {24'd0, busy}, 32'd0);
      chk("rst_err", {24'd0, addr_err}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: all inputs to output 7, single-beat packets.
      for (int i = 0; i < 8; i++) start(i, 7, 1);
      tick();
      for (int k = 0; k < 8; k++) begin
         tick(); chk("t1_grant", {24'd0, g_obs}, 32'd1 << k);
         tick(); chk("t1_bubble", {24'd0, g_obs}, 32'd0);
      end
      drain(20);

      // 2: every input to its own output in the same cycle.
      for (int i = 0; i < 8; i++) start(i, i, 1);
      tick();
      tick(); chk("t2_grant", {24'd0, g_obs}, 32'hFF);
      tick(); chk("t2_busy", {24'd0, b_obs}, 32'h00);
      drain(20);

      // 3: 4-beat packet on output 5 with one backpressure cycle, contender waits.
      start(3, 5, 4);
      tick();
      start(6, 5, 1);
      g3 = '0; g6 = '0;
      for (int c = 0; c < 7; c++) begin
         out_ready = (c == 1) ? 8'hDF : 8'hFF;
         tick();
         g3[c] = g_obs[3]; g6[c] = g_obs[6];
      end
      out_ready = 8'hFF;
      chk("t3_grant3", {24'd0, g3}, 32'b0011101);
      chk("t3_grant6", {24'd0, g6}, 32'b1000000);
      drain(20);

      // 4: invalid destination on input 2 while input 0 runs normally.
      start(2, 10, 1);
      start(0, 3, 2);
      tick();
      tick(); chk("t4_err", {24'd0, e_obs}, 32'h04);
      for (int c = 0; c < 4; c++) begin tick(); chk("t4_nogrant2", {31'd0, g_obs[2]}, 32'd0); end
      plen[2] = 0; drive();
      tick(); tick(); chk("t4_err_clear", {24'd0, e_obs}, 32'h00);
      drain(20);

      // 5: reset mid-packet, then fresh arbitration from ptr=0.
      start(0, 7, 4);
      tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("t5_rst_grant", {24'd0, grant}, 32'd0);
      chk("t5_rst_busy", {24'd0, busy}, 32'd0);
      model_reset();
      for (int i = 0; i < 8; i++) plen[i] = 0;
      drive();
      @(posedge clk); #1;
      rst_n = 1'b1;
      start(4, 7, 1); start(1, 7, 1);
      tick();
      tick(); chk("t5_winner", {24'd0, g_obs}, 32'h02);
      drain(20);

      // 6: after input 5 finishes on output 7, input 6 beats input 2.
      start(5, 7, 2);
      drain(20);
      start(2, 7, 1); start(6, 7, 1);
      tick();
      tick(); chk("t6_first", {24'd0, g_obs}, 32'h40);
      tick(); chk("t6_gap", {24'd0, g_obs}, 32'h00);
      tick(); chk("t6_second", {24'd0, g_obs}, 32'h04);
      drain(20);

      // Randomized traffic with backpressure, pauses and occasional invalid addresses.
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < 8; i++) begin
            if (plen[i] == 0 && $urandom_range(0, 3) == 0) begin
               dst[i] = $urandom_range(0, 9);
               plen[i] = $urandom_range(1, 4);
            end else if (plen[i] > 0 && dst[i] >= 8 && $urandom_range(0, 2) == 0) begin
               plen[i] = 0;
            end
            pause[i] = ($urandom_range(0, 9) == 0);
         end
         out_ready = 8'($urandom);
         drive();
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         pause[i] = 0;
         if (dst[i] >= 8) plen[i] = 0;
      end
      out_ready = 8'hFF;
      drive();
      drain(200);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
